alu_issue_ctrl: RTL and testbench

Issue controller for the 4-stage pipelined 16-bit ALU. Two requesters present ALU operations over valid/ready handshakes. The block arbitrates between them round-robin and holds back any operation whose source registers are still being written by an in-flight operation (RAW hazard). It drives one operation per cycle at most into the ALU's rs1/rs2/rd/func/addr inputs, rejects illegal function codes, and keeps a stall counter.

---
 rtl/alu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-stage 16-bit ALU: round-robin arbitration of two requesters,
// RAW hazard hold-off via a shifting rd scoreboard, illegal-func drop and a saturating stall counter.
module alu_issue_ctrl #(
   parameter int HAZ_DEPTH = 4,
   parameter int STALL_W   = 16
) (
   input  logic                clk1,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   input  logic [1:0][23:0]    req_op,
   output logic [1:0]          req_ready,
   output logic                iss_valid,
   output logic [3:0]          iss_rs1,
   output logic [3:0]          iss_rs2,
   output logic [3:0]          iss_rd,
   output logic [3:0]          iss_func,
   output logic [7:0]          iss_addr,
   output logic                iss_id,
   output logic                err,
   output logic                err_id,
   output logic [STALL_W-1:0]  stall_cnt
);

   localparam logic [3:0]         FUNC_MAX  = 4'd11;
   localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   logic [HAZ_DEPTH-1:0] sb_v;
   logic [3:0]           sb_rd [HAZ_DEPTH];
   logic                 ptr;

   logic [1:0]  illegal;
   logic [1:0]  hazard;
   logic [1:0]  elig;
   logic        grant;
   logic        win;
   logic        acc_legal;
   logic        acc_illegal;
   logic [23:0] win_op;

   // Slots are compared with their pre-edge contents, so the retiring slot still blocks.
   always_comb begin
      illegal = '0;
      hazard  = '0;
      elig    = '0;
      for (int i = 0; i < 2; i++) begin
         illegal[i] = req_op[i][23:20] > FUNC_MAX;
         for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (sb_v[k] && ((sb_rd[k] == req_op[i][19:16]) || (sb_rd[k] == req_op[i][15:12])))
               hazard[i] = 1'b1;
         end
         elig[i] = req_valid[i] & (illegal[i] | ~hazard[i]);
      end
   end

   always_comb begin
      grant     = 1'b0;
      win       = ptr;
      req_ready = '0;
      if (elig[ptr]) begin
         grant = 1'b1;
         win   = ptr;
      end else if (elig[~ptr]) begin
         grant = 1'b1;
         win   = ~ptr;
      end
      if (!rst_n)
         grant = 1'b0;
      if (grant)
         req_ready[win] = 1'b1;
      win_op      = req_op[win];
      acc_legal   = grant & ~illegal[win];
      acc_illegal = grant & illegal[win];
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         sb_v      <= '0;
         for (int k = 0; k < HAZ_DEPTH; k++)
            sb_rd[k] <= '0;
         ptr       <= 1'b0;
         iss_valid <= 1'b0;
         iss_rs1   <= '0;
         iss_rs2   <= '0;
         iss_rd    <= '0;
         iss_func  <= '0;
         iss_addr  <= '0;
         iss_id    <= 1'b0;
         err       <= 1'b0;
         err_id    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         sb_v     <= {sb_v[HAZ_DEPTH-2:0], acc_legal};
         sb_rd[0] <= win_op[11:8];
         for (int k = 1; k < HAZ_DEPTH; k++)
            sb_rd[k] <= sb_rd[k-1];

         if (grant)
            ptr <= ~win;

         iss_valid <= acc_legal;
         if (acc_legal) begin
            iss_func <= win_op[23:20];
            iss_rs1  <= win_op[19:16];
            iss_rs2  <= win_op[15:12];
            iss_rd   <= win_op[11:8];
            iss_addr <= win_op[7:0];
            iss_id   <= win;
         end

         err <= acc_illegal;
         if (acc_illegal)
            err_id <= win;

         if ((|req_valid) && !grant && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios with literal expectations, then random traffic
// checked each cycle against a reference model built from accept history.
module tb_alu_issue_ctrl;
   localparam int HAZ_DEPTH = 4;
   localparam int STALL_W   = 16;
   localparam int SAT_W     = 4;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0][23:0]  req_op;

   logic [1:0]        req_ready;
   logic              iss_valid;
   logic [3:0]        iss_rs1, iss_rs2, iss_rd, iss_func;
   logic [7:0]        iss_addr;
   logic              iss_id, err, err_id;
   logic [STALL_W-1:0] stall_cnt;

   logic [1:0]        req_ready_s;
   logic              iss_valid_s;
   logic [3:0]        iss_rs1_s, iss_rs2_s, iss_rd_s, iss_func_s;
   logic [7:0]        iss_addr_s;
   logic              iss_id_s, err_s, err_id_s;
   logic [SAT_W-1:0]  stall_cnt_s;

   always #5 clk1 = ~clk1;

   alu_issue_ctrl #(.HAZ_DEPTH(HAZ_DEPTH), .STALL_W(STALL_W)) dut (
      .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_ready(req_ready), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr), .iss_id(iss_id),
      .err(err), .err_id(err_id), .stall_cnt(stall_cnt));

   alu_issue_ctrl #(.HAZ_DEPTH(HAZ_DEPTH), .STALL_W(SAT_W)) dut_s (
      .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_ready(req_ready_s), .iss_valid(iss_valid_s), .iss_rs1(iss_rs1_s), .iss_rs2(iss_rs2_s),
      .iss_rd(iss_rd_s), .iss_func(iss_func_s), .iss_addr(iss_addr_s), .iss_id(iss_id_s),
      .err(err_s), .err_id(err_id_s), .stall_cnt(stall_cnt_s));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] mk(input int f, input int r1, input int r2, input int rd, input int a);
      logic [23:0] o;
      o = {f[3:0], r1[3:0], r2[3:0], rd[3:0], a[7:0]};
      return o;
   endfunction

   // Reference model: a request is blocked if a legal op accepted 1..HAZ_DEPTH cycles ago wrote one of its sources.
   int cyc = 0;
   int acc_cyc[$];
   int acc_rd[$];
   int pref;
   bit known = 0;
   int e_valid, e_rs1, e_rs2, e_rd, e_func, e_addr, e_id, e_err, e_err_id;
   int e_stall, e_stall_s;

   function automatic bit m_blocked(input int r1, input int r2);
      bit b = 0;
      for (int j = 0; j < acc_cyc.size(); j++)
         if ((cyc - acc_cyc[j] <= HAZ_DEPTH) && (acc_rd[j] == r1 || acc_rd[j] == r2))
            b = 1;
      return b;
   endfunction

   always @(negedge clk1) begin
      bit [1:0] el;
      bit       g;
      int       w, er, f;
      logic [23:0] op;
      if (known) begin
         chk("m_iss_valid", iss_valid, e_valid);
         chk("m_iss_rs1", iss_rs1, e_rs1);
         chk("m_iss_rs2", iss_rs2, e_rs2);
         chk("m_iss_rd", iss_rd, e_rd);
         chk("m_iss_func", iss_func, e_func);
         chk("m_iss_addr", iss_addr, e_addr);
         if (e_valid != 0) chk("m_iss_id", iss_id, e_id);
         chk("m_err", err, e_err);
         if (e_err != 0) chk("m_err_id", err_id, e_err_id);
         chk("m_stall", stall_cnt, e_stall);
         chk("m_stall_sat", stall_cnt_s, e_stall_s);
      end
      while (acc_cyc.size() > 0 && cyc - acc_cyc[0] > HAZ_DEPTH) begin
         void'(acc_cyc.pop_front());
         void'(acc_rd.pop_front());
      end
      el = '0;
      for (int i = 0; i < 2; i++) begin
         op = req_op[i];
         el[i] = req_valid[i] && (op[23:20] > 4'd11 || !m_blocked(int'(op[19:16]), int'(op[15:12])));
      end
      g = 0;
      w = pref;
      if (rst_n === 1'b1 && known) begin
         if (el[pref]) begin g = 1; w = pref; end
         else if (el[1-pref]) begin g = 1; w = 1 - pref; end
      end
      er = g ? (1 << w) : 0;
      chk("m_req_ready", req_ready, er);
      chk("m_req_ready_sat", req_ready_s, er);

      if (rst_n !== 1'b1) begin
         known = 1;
         acc_cyc.delete();
         acc_rd.delete();
         pref = 0;
         e_valid = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_func = 0; e_addr = 0;
         e_id = 0; e_err = 0; e_err_id = 0; e_stall = 0; e_stall_s = 0;
      end else if (known) begin
         e_valid = 0;
         e_err   = 0;
         if (g) begin
            op = req_op[w];
            f  = int'(op[23:20]);
            if (f > 11) begin
               e_err = 1;
               e_err_id = w;
            end else begin
               e_valid = 1;
               e_func = f;
               e_rs1 = int'(op[19:16]);
               e_rs2 = int'(op[15:12]);
               e_rd = int'(op[11:8]);
               e_addr = int'(op[7:0]);
               e_id = w;
               acc_cyc.push_back(cyc);
               acc_rd.push_back(int'(op[11:8]));
            end
            pref = 1 - w;
         end else if (req_valid != 2'b00) begin
            if (e_stall < (1 << STALL_W) - 1) e_stall++;
            if (e_stall_s < (1 << SAT_W) - 1) e_stall_s++;
         end
      end
      cyc++;
   end

   task automatic do_reset();
      @(posedge clk1); #1;
      rst_n = 1'b0;
      req_valid = 2'b00;
      @(posedge clk1); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] rdy;
      rst_n = 1'b0;
      req_valid = 2'b11;
      req_op[0] = mk(0, 1, 2, 3, 8'h10);
      req_op[1] = mk(7, 4, 5, 6, 8'h20);

      // reset with both requesters valid
      repeat (2) begin
         @(negedge clk1);
         chk("rst_ready", req_ready, 0);
         chk("rst_iss_valid", iss_valid, 0);
         chk("rst_stall", stall_cnt, 0);
      end
      @(posedge clk1); #1;
      rst_n = 1'b1;

      // round robin between independent ops
      @(negedge clk1);
      chk("first_grant", req_ready, 2'b01);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk1);
         chk("rr_iss_valid", iss_valid, 1);
         chk("rr_iss_id", iss_id, n % 2);
         chk("rr_stall", stall_cnt, 0);
      end

      // RAW stall on rd=3
      do_reset();
      req_valid = 2'b01;
      req_op[0] = mk(0, 1, 2, 3, 8'h11);
      @(negedge clk1);
      chk("raw_prod_ready", req_ready, 2'b01);
      @(posedge clk1); #1;
      req_op[0] = mk(1, 3, 0, 4, 8'h12);
      repeat (4) begin
         @(negedge clk1);
         chk("raw_blocked", req_ready, 0);
      end
      @(negedge clk1);
      chk("raw_release", req_ready, 2'b01);
      @(posedge clk1); #1;
      req_valid = 2'b00;
      @(negedge clk1);
      chk("raw_iss_valid", iss_valid, 1);
      chk("raw_iss_func", iss_func, 1);
      chk("raw_iss_rs1", iss_rs1, 3);
      chk("raw_stall", stall_cnt, 4);

      // r1 bypasses a blocked r0, pointer ends back on r0
      do_reset();
      req_valid = 2'b10;
      req_op[1] = mk(7, 4, 5, 3, 8'h21);
      @(negedge clk1);
      chk("byp_prod", req_ready, 2'b10);
      @(posedge clk1); #1;
      req_valid = 2'b11;
      req_op[0] = mk(1, 3, 0, 4, 8'h00);
      req_op[1] = mk(6, 7, 8, 9, 8'h22);
      @(negedge clk1);
      chk("byp_ready", req_ready, 2'b10);
      @(posedge clk1); #1;
      req_op[0] = mk(0, 1, 2, 10, 8'h00);
      req_op[1] = mk(0, 1, 2, 11, 8'h00);
      @(negedge clk1);
      chk("byp_iss_rd", iss_rd, 9);
      chk("byp_ptr", req_ready, 2'b01);

      // illegal func dropped, leaves no scoreboard entry
      do_reset();
      req_valid = 2'b10;
      req_op[1] = mk(13, 0, 0, 5, 8'h33);
      @(negedge clk1);
      chk("ill_ready", req_ready, 2'b10);
      @(posedge clk1); #1;
      req_valid = 2'b01;
      req_op[0] = mk(0, 5, 5, 6, 8'h00);
      @(negedge clk1);
      chk("ill_err", err, 1);
      chk("ill_err_id", err_id, 1);
      chk("ill_iss_valid", iss_valid, 0);
      chk("ill_no_block", req_ready, 2'b01);

      // self-dependent stream: one accept then four stall cycles, five times
      do_reset();
      req_valid = 2'b01;
      req_op[0] = mk(0, 3, 3, 3, 8'h44);
      repeat (25) @(posedge clk1);
      #1;
      req_valid = 2'b00;
      @(negedge clk1);
      chk("sat_cnt4", stall_cnt_s, 15);
      chk("sat_cnt16", stall_cnt, 20);

      // random traffic, requests held until accepted
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk1);
         rdy = req_ready;
         @(posedge clk1); #1;
         rst_n = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || rdy[i]) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               req_op[i] = mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 255));
            end
         end
      end
      @(posedge clk1); #1;
      req_valid = 2'b00;
      rst_n = 1'b1;
      repeat (3) @(negedge clk1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
